// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions until all source operands
// are resolved (at allocation, by bypass, or by result-bus snoop), then issues in index order.

module rs_entry #(
    parameter int RS_ID_WIDTH   = 5,
    parameter int OPERANDS      = 2,
    parameter int OPERAND_WIDTH = 32,
    parameter int CONTROL_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alloc_i,
    input  logic                              free_i,
    input  logic [CONTROL_WIDTH-1:0]          ctrl_i,
    input  logic [OPERANDS-1:0]               op_valid_i,
    input  logic [OPERANDS*RS_ID_WIDTH-1:0]   op_tag_i,
    input  logic [OPERANDS*OPERAND_WIDTH-1:0] op_value_i,
    input  logic                              result_valid_i,
    input  logic [RS_ID_WIDTH-1:0]            result_rs_id_i,
    input  logic [OPERAND_WIDTH-1:0]          result_value_i,
    output logic                              busy_o,
    output logic                              eligible_o,
    output logic [CONTROL_WIDTH-1:0]          ctrl_o,
    output logic [OPERANDS*OPERAND_WIDTH-1:0] value_o
);
    logic                                         busy_q, busy_d;
    logic [OPERANDS-1:0]                          valid_q, valid_d;
    logic [CONTROL_WIDTH-1:0]                     ctrl_q, ctrl_d;
    logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]         tag_q, tag_d;
    logic [OPERANDS-1:0][OPERAND_WIDTH-1:0]       value_q, value_d;

    always_comb begin
        busy_d  = busy_q;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        tag_d   = tag_q;
        value_d = value_q;
        if (alloc_i) begin
            busy_d = 1'b1;
            ctrl_d = ctrl_i;
            for (int j = 0; j < OPERANDS; j++) begin
                tag_d[j] = op_tag_i[j*RS_ID_WIDTH +: RS_ID_WIDTH];
                if (op_valid_i[j]) begin
                    valid_d[j] = 1'b1;
                    value_d[j] = op_value_i[j*OPERAND_WIDTH +: OPERAND_WIDTH];
                end else if (result_valid_i && tag_d[j] == result_rs_id_i) begin
                    // Producer completes in the allocation cycle: capture it now or it is lost.
                    valid_d[j] = 1'b1;
                    value_d[j] = result_value_i;
                end else begin
                    valid_d[j] = 1'b0;
                    value_d[j] = '0;
                end
            end
        end else begin
            for (int j = 0; j < OPERANDS; j++) begin
                if (busy_q && !valid_q[j] && result_valid_i && tag_q[j] == result_rs_id_i) begin
                    valid_d[j] = 1'b1;
                    value_d[j] = result_value_i;
                end
            end
            if (free_i) begin
                busy_d  = 1'b0;
                valid_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        ctrl_q  <= ctrl_d;
        tag_q   <= tag_d;
        value_q <= value_d;
    end

    assign busy_o     = busy_q;
    assign eligible_o = busy_q && (&valid_q);
    assign ctrl_o     = ctrl_q;
    assign value_o    = value_q;
endmodule

module reservation_station #(
    parameter int RS_ID_WIDTH   = 5,
    parameter int RS_OFFSET     = 0,
    parameter int RS_DEPTH      = 4,
    parameter int OPERANDS      = 2,
    parameter int OPERAND_WIDTH = 32,
    parameter int CONTROL_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              input_valid,
    output logic                              input_ready,
    input  logic [CONTROL_WIDTH-1:0]          input_control,
    input  logic [OPERANDS-1:0]               input_op_valid,
    input  logic [OPERANDS*RS_ID_WIDTH-1:0]   input_op_tag,
    input  logic [OPERANDS*OPERAND_WIDTH-1:0] input_op_value,
    output logic [RS_ID_WIDTH-1:0]            rs_id,
    input  logic                              result_valid,
    input  logic [RS_ID_WIDTH-1:0]            result_rs_id,
    input  logic [OPERAND_WIDTH-1:0]          result_value,
    output logic                              issue_valid,
    input  logic                              issue_ready,
    output logic [CONTROL_WIDTH-1:0]          issue_control,
    output logic [OPERANDS*OPERAND_WIDTH-1:0] issue_value,
    output logic [RS_ID_WIDTH-1:0]            issue_rs_id
);
    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [RS_DEPTH-1:0]                              busy, eligible, alloc_vec, free_vec;
    logic [RS_DEPTH-1:0][CONTROL_WIDTH-1:0]           ent_ctrl;
    logic [RS_DEPTH-1:0][OPERANDS*OPERAND_WIDTH-1:0]  ent_value;

    logic             free_any, elig_any, sel_valid;
    logic [IDX_W-1:0] free_idx, elig_idx, sel_idx;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    for (genvar k = 0; k < RS_DEPTH; k++) begin : g_entry
        rs_entry #(
            .RS_ID_WIDTH  (RS_ID_WIDTH),
            .OPERANDS     (OPERANDS),
            .OPERAND_WIDTH(OPERAND_WIDTH),
            .CONTROL_WIDTH(CONTROL_WIDTH)
        ) u_entry (
            .clk           (clk),
            .rst           (rst),
            .alloc_i       (alloc_vec[k]),
            .free_i        (free_vec[k]),
            .ctrl_i        (input_control),
            .op_valid_i    (input_op_valid),
            .op_tag_i      (input_op_tag),
            .op_value_i    (input_op_value),
            .result_valid_i(result_valid),
            .result_rs_id_i(result_rs_id),
            .result_value_i(result_value),
            .busy_o        (busy[k]),
            .eligible_o    (eligible[k]),
            .ctrl_o        (ent_ctrl[k]),
            .value_o       (ent_value[k])
        );
    end

    // Descending scans so the lowest matching index wins.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        elig_any = 1'b0;
        elig_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (eligible[i]) begin
                elig_any = 1'b1;
                elig_idx = IDX_W'(i);
            end
        end
    end

    assign sel_idx   = lock_q ? lock_idx_q : elig_idx;
    assign sel_valid = !rst && (lock_q || elig_any);

    always_comb begin
        alloc_vec = '0;
        free_vec  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            alloc_vec[i] = input_valid && free_any && (free_idx == IDX_W'(i));
            free_vec[i]  = sel_valid && issue_ready && (sel_idx == IDX_W'(i));
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (sel_valid && !issue_ready) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end else if (sel_valid && issue_ready) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign input_ready   = rst || free_any;
    assign rs_id         = (rst || free_any) ?
                           RS_ID_WIDTH'(RS_OFFSET) + (rst ? '0 : RS_ID_WIDTH'(free_idx)) : '0;
    assign issue_valid   = sel_valid;
    assign issue_control = sel_valid ? ent_ctrl[sel_idx] : '0;
    assign issue_value   = sel_valid ? ent_value[sel_idx] : '0;
    assign issue_rs_id   = sel_valid ? RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(sel_idx) : '0;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with RS_OFFSET=4, depth 4, two 32-bit operands.

module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst;
    logic        input_valid, input_ready;
    logic [15:0] input_control;
    logic [1:0]  input_op_valid;
    logic [9:0]  input_op_tag;
    logic [63:0] input_op_value;
    logic [4:0]  rs_id;
    logic        result_valid;
    logic [4:0]  result_rs_id;
    logic [31:0] result_value;
    logic        issue_valid, issue_ready;
    logic [15:0] issue_control;
    logic [63:0] issue_value;
    logic [4:0]  issue_rs_id;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    reservation_station #(
        .RS_ID_WIDTH(5), .RS_OFFSET(4), .RS_DEPTH(4),
        .OPERANDS(2), .OPERAND_WIDTH(32), .CONTROL_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .input_valid(input_valid), .input_ready(input_ready),
        .input_control(input_control), .input_op_valid(input_op_valid),
        .input_op_tag(input_op_tag), .input_op_value(input_op_value),
        .rs_id(rs_id),
        .result_valid(result_valid), .result_rs_id(result_rs_id), .result_value(result_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_control(issue_control), .issue_value(issue_value), .issue_rs_id(issue_rs_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (issue_valid && issue_ready) hs_cnt <= hs_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alloc(input logic [15:0] c, input logic [1:0] v,
                               input logic [9:0] tags, input logic [63:0] vals);
        input_valid    = 1'b1;
        input_control  = c;
        input_op_valid = v;
        input_op_tag   = tags;
        input_op_value = vals;
    endtask

    task automatic end_alloc();
        input_valid    = 1'b0;
        input_op_valid = '0;
        input_op_tag   = '0;
        input_op_value = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL reset_input_ready got=%0b exp=1", input_ready); end
        checks++; if (rs_id !== 5'd4) begin errors++; $display("FAIL reset_rs_id got=%0d exp=4", rs_id); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%0b exp=0", issue_valid); end
        checks++; if ({issue_control, issue_value, issue_rs_id} !== '0) begin errors++; $display("FAIL reset_issue_outs got=%h exp=0", {issue_control, issue_value, issue_rs_id}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_issue();
        drive_alloc(16'hA1, 2'b11, 10'd0, {32'd7, 32'd5});
        #1;
        checks++; if (rs_id !== 5'd4) begin errors++; $display("FAIL t1_alloc_rs_id got=%0d exp=4", rs_id); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL t1_no_passthrough got=%0b exp=0", issue_valid); end
        step();
        end_alloc();
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL t1_issue_valid got=%0b exp=1", issue_valid); end
        checks++; if (issue_value !== {32'd7, 32'd5}) begin errors++; $display("FAIL t1_issue_value got=%h exp=%h", issue_value, {32'd7, 32'd5}); end
        checks++; if (issue_rs_id !== 5'd4) begin errors++; $display("FAIL t1_issue_rs_id got=%0d exp=4", issue_rs_id); end
        checks++; if (issue_control !== 16'hA1) begin errors++; $display("FAIL t1_issue_control got=%h exp=00a1", issue_control); end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL t1_after_accept got=%0b exp=0", issue_valid); end
    endtask

    task automatic test_snoop();
        drive_alloc(16'hB2, 2'b10, {5'd0, 5'd9}, {32'h11, 32'h0});
        step();
        end_alloc();
        step();
        result_valid = 1'b1; result_rs_id = 5'd9; result_value = 32'h55;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL t2_wait_valid got=%0b exp=0", issue_valid); end
        step();
        result_valid = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL t2_issue_valid got=%0b exp=1", issue_valid); end
        checks++; if (issue_value !== {32'h11, 32'h55}) begin errors++; $display("FAIL t2_issue_value got=%h exp=%h", issue_value, {32'h11, 32'h55}); end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            drive_alloc(16'(k), 2'b11, 10'd0, {32'(k + 100), 32'(k)});
            step();
        end
        end_alloc();
        #1;
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL t3_full_ready got=%0b exp=0", input_ready); end
        checks++; if (rs_id !== 5'd0) begin errors++; $display("FAIL t3_full_rs_id got=%0d exp=0", rs_id); end
        checks++; if (issue_rs_id !== 5'd4) begin errors++; $display("FAIL t3_first_issue got=%0d exp=4", issue_rs_id); end
        issue_ready = 1'b1;
        #1;
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL t3_no_same_cycle_free got=%0b exp=0", input_ready); end
        step();
        issue_ready = 1'b0;
        #1;
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL t3_freed_ready got=%0b exp=1", input_ready); end
        checks++; if (rs_id !== 5'd4) begin errors++; $display("FAIL t3_freed_rs_id got=%0d exp=4", rs_id); end
        issue_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            checks++; if (issue_rs_id !== 5'(4 + k) || issue_value !== {32'(k + 100), 32'(k)}) begin
                errors++; $display("FAIL t3_drain_%0d got id=%0d val=%h exp id=%0d", k, issue_rs_id, issue_value, 4 + k);
            end
            step();
        end
        issue_ready = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0 || issue_value !== '0) begin errors++; $display("FAIL t3_empty got v=%0b val=%h exp 0", issue_valid, issue_value); end
    endtask

    task automatic test_lock();
        drive_alloc(16'h1, 2'b10, {5'd0, 5'd20}, {32'h1, 32'h0});
        step();
        drive_alloc(16'h2, 2'b10, {5'd0, 5'd21}, {32'h2, 32'h0});
        step();
        drive_alloc(16'h3, 2'b11, 10'd0, {32'h201, 32'h200});
        step();
        end_alloc();
        result_valid = 1'b1; result_rs_id = 5'd20; result_value = 32'hAB;
        #1;
        checks++; if (issue_rs_id !== 5'd6) begin errors++; $display("FAIL t4_present2 got=%0d exp=6", issue_rs_id); end
        step();
        result_valid = 1'b0;
        #1;
        checks++; if (issue_rs_id !== 5'd6 || issue_value !== {32'h201, 32'h200}) begin errors++; $display("FAIL t4_locked got id=%0d val=%h exp id=6", issue_rs_id, issue_value); end
        step();
        checks++; if (issue_rs_id !== 5'd6 || issue_control !== 16'h3) begin errors++; $display("FAIL t4_still_locked got id=%0d ctl=%h exp id=6", issue_rs_id, issue_control); end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        #1;
        checks++; if (issue_rs_id !== 5'd4 || issue_value !== {32'h1, 32'hAB}) begin errors++; $display("FAIL t4_entry0_next got id=%0d val=%h exp id=4", issue_rs_id, issue_value); end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL t4_entry1_waits got=%0b exp=0", issue_valid); end
        result_valid = 1'b1; result_rs_id = 5'd21; result_value = 32'hCD;
        step();
        result_valid = 1'b0;
        issue_ready = 1'b1;
        #1;
        checks++; if (issue_rs_id !== 5'd5 || issue_value !== {32'h2, 32'hCD}) begin errors++; $display("FAIL t4_entry1 got id=%0d val=%h exp id=5", issue_rs_id, issue_value); end
        step();
        issue_ready = 1'b0;
    endtask

    task automatic test_bypass();
        drive_alloc(16'h5, 2'b10, {5'd0, 5'd3}, {32'h22, 32'h0});
        result_valid = 1'b1; result_rs_id = 5'd3; result_value = 32'h33;
        step();
        end_alloc();
        result_valid = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_value !== {32'h22, 32'h33}) begin errors++; $display("FAIL t5_bypass got v=%0b val=%h exp v=1 val=%h", issue_valid, issue_value, {32'h22, 32'h33}); end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
    endtask

    task automatic test_multi_snoop();
        drive_alloc(16'h6, 2'b10, {5'd0, 5'd12}, {32'h1, 32'h0});
        step();
        drive_alloc(16'h7, 2'b01, {5'd12, 5'd0}, {32'h0, 32'h2});
        step();
        end_alloc();
        result_valid = 1'b1; result_rs_id = 5'd12; result_value = 32'h77;
        step();
        result_valid = 1'b0;
        issue_ready = 1'b1;
        #1;
        checks++; if (issue_rs_id !== 5'd4 || issue_value !== {32'h1, 32'h77}) begin errors++; $display("FAIL ms_entry0 got id=%0d val=%h exp id=4", issue_rs_id, issue_value); end
        step();
        checks++; if (issue_rs_id !== 5'd5 || issue_value !== {32'h77, 32'h2}) begin errors++; $display("FAIL ms_entry1 got id=%0d val=%h exp id=5", issue_rs_id, issue_value); end
        step();
        issue_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int hs0;
        for (int k = 0; k < 3; k++) begin
            drive_alloc(16'(k + 8), 2'b11, 10'd0, {32'(k), 32'(k)});
            step();
        end
        end_alloc();
        step();
        hs0 = hs_cnt;
        rst = 1'b1;
        issue_ready = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b0 || input_ready !== 1'b1 || rs_id !== 5'd4) begin errors++; $display("FAIL t6_in_reset got v=%0b rdy=%0b id=%0d exp 0/1/4", issue_valid, input_ready, rs_id); end
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0 || input_ready !== 1'b1 || rs_id !== 5'd4) begin errors++; $display("FAIL t6_after_reset got v=%0b rdy=%0b id=%0d exp 0/1/4", issue_valid, input_ready, rs_id); end
        step();
        step();
        checks++; if (hs_cnt !== hs0) begin errors++; $display("FAIL t6_no_handshake got=%0d exp=%0d", hs_cnt, hs0); end
        issue_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        input_valid = 1'b0; input_control = '0; input_op_valid = '0;
        input_op_tag = '0; input_op_value = '0;
        result_valid = 1'b0; result_rs_id = '0; result_value = '0;
        issue_ready = 1'b0;
        test_reset();
        test_basic_issue();
        test_snoop();
        test_back_to_back();
        test_lock();
        test_bypass();
        test_multi_snoop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 Parameter RS_ID_WIDTH, default 5: width of the reservation-station ID and result tags.
REQ-003 Parameter RS_OFFSET, default 0: global ID of entry 0; entry k SHALL have ID RS_OFFSET+k.
REQ-004 Parameter RS_DEPTH, default 4: number of entries (2..8).
REQ-005 Parameter OPERANDS, default 2: source operands per entry.
REQ-006 Parameter OPERAND_WIDTH, default 32: operand and result value width.
REQ-007 Parameter CONTROL_WIDTH, default 16: opaque decoded-control payload width.
REQ-008 clk  in  1  clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 input_valid  in  1  dispatcher offers an instruction.
REQ-011 input_ready  out  1  a free entry exists.
REQ-012 input_control  in  CONTROL_WIDTH  decoded control payload.
REQ-013 input_op_valid  in  OPERANDS  per-operand value-present flag.
REQ-014 input_op_tag  in  OPERANDS*RS_ID_WIDTH  producer ID for each absent operand.
REQ-015 input_op_value  in  OPERANDS*OPERAND_WIDTH  operand values, meaningful where op_valid=1.
REQ-016 rs_id  out  RS_ID_WIDTH  ID the offered instruction will occupy.
REQ-017 result_valid  in  1  result bus broadcast is valid.
REQ-018 result_rs_id  in  RS_ID_WIDTH  tag of the broadcast result.
REQ-019 result_value  in  OPERAND_WIDTH  broadcast value.
REQ-020 issue_valid  out  1  an entry is presented to the execution unit.
REQ-021 issue_ready  in  1  execution unit accepts.
REQ-022 issue_control  out  CONTROL_WIDTH  control payload of the issuing entry.
REQ-023 issue_value  out  OPERANDS*OPERAND_WIDTH  resolved operands of the issuing entry.
REQ-024 issue_rs_id  out  RS_ID_WIDTH  ID of the issuing entry, used later as the result tag.

Function
REQ-025 Each entry SHALL hold: busy, control, and per operand a valid bit, tag and value.
REQ-026 input_ready SHALL be 1 iff any entry is not busy, evaluated from registered state only.
REQ-027 rs_id SHALL be RS_OFFSET plus the lowest non-busy index; when the station is full, rs_id SHALL be 0.
REQ-028 On a clock edge with input_valid&&input_ready, the lowest free entry SHALL be loaded and set busy.
REQ-029 Allocation bypass: when an incoming operand has op_valid=0 and its tag equals result_rs_id while result_valid=1 in the same cycle, the entry SHALL store result_value with the valid bit set.
REQ-030 Snoop: on each edge with result_valid=1, every busy entry operand with valid=0 and tag==result_rs_id SHALL capture result_value and set valid; all matching entries SHALL update in the same cycle.
REQ-031 An entry SHALL be eligible once busy and all operand valid bits are 1; the earliest issue is the cycle after allocation (no same-cycle pass-through).
REQ-032 Selection: when no selection is locked, the lowest-index eligible entry SHALL be presented, with issue_valid=1.
REQ-033 Lock: if issue_valid=1 and issue_ready=0, the presented index SHALL be locked; issue outputs SHALL remain stable until the handshake, even if lower entries become eligible.
REQ-034 On issue_valid&&issue_ready, the entry SHALL become not busy and the lock SHALL clear; a new selection SHALL be presented no earlier than the next cycle.
REQ-035 A freed entry SHALL NOT be reallocated in the cycle it is freed; input_ready SHALL reflect the freed entry from the next cycle.
REQ-036 Simultaneous allocation, snoop and issue in one cycle SHALL all take effect independently.
REQ-037 When no entry is eligible, issue_valid SHALL be 0 and the other issue outputs SHALL be 0.

Reset
REQ-038 On rst=1 at a clock edge, all entries SHALL become not busy, operand valid bits SHALL clear, and the lock SHALL clear.
REQ-039 While in reset and after reset, the outputs SHALL be: input_ready=1, rs_id=RS_OFFSET, issue_valid=0, and all issue outputs 0.
REQ-040 Reset mid-operation SHALL discard all entries without issuing any of them.

Verification
REQ-041 Test 1: RS_OFFSET=4; allocate an entry with both operands valid (5, 7) -> rs_id=4 at allocation; issue_valid=1 next cycle with values 5 and 7 and issue_rs_id=4.
REQ-042 Test 2: allocate with op0 tag=9 absent; broadcast result_rs_id=9, value=0x55 two cycles later -> issue_valid rises the cycle after the broadcast with op0=0x55.
REQ-043 Test 3: fill all 4 entries -> input_ready=0 and rs_id=0; issue one entry -> input_ready=1 one cycle after the handshake, with rs_id equal to the freed index.
REQ-044 Test 4: entry 2 is presented with issue_ready=0, then entry 0 becomes eligible -> outputs stay on entry 2 until accepted, and entry 0 is presented the next cycle.
REQ-045 Test 5: broadcast tag=3 in the same cycle as an allocation awaiting tag 3 -> the operand is captured via bypass and the entry issues the next cycle.
REQ-046 Test 6: assert rst with 3 entries busy and one locked -> issue_valid=0, input_ready=1, rs_id=RS_OFFSET, and no issue handshake occurs.
